// File: rtl/dec_pkg.sv
// ---------------------------------------------------------------------------
// dec_pkg
// Shared defaults for the indexed-event decoder slice.
//   DEC_N     : default number of decoded lines
//   DEC_W     : default index width
//   DEC_CNT_W : default width of the duplicate-drop counter
//   onehot()  : decodes an index into DEC_N bits (all zero when out of range)
// ---------------------------------------------------------------------------
package dec_pkg;

    localparam int DEC_N     = 8;
    localparam int DEC_W     = $clog2(DEC_N);
    localparam int DEC_CNT_W = 8;

    function automatic logic [DEC_N-1:0] onehot(input logic [DEC_W-1:0] idx);
        logic [DEC_N-1:0] oh;
        oh = '0;
        for (int i = 0; i < DEC_N; i++) begin
            oh[i] = (idx == DEC_W'(i));
        end
        return oh;
    endfunction

endpackage

// File: rtl/dec_8b_pend_onehot.sv
// ---------------------------------------------------------------------------
// dec_onehot
// Purely combinational W-to-N decoder with range check.
// Ports:
//   idx_i : encoded index (W bits)
//   oh_o  : one-hot of idx_i at width N; all zero when idx_i >= N
//   ok_o  : 1 when idx_i < N (idx_i zero-extended for the compare)
// ---------------------------------------------------------------------------
module dec_onehot
    import dec_pkg::*;
#(
    parameter int N = DEC_N,
    parameter int W = $clog2(N)
) (
    input  logic [W-1:0] idx_i,
    output logic [N-1:0] oh_o,
    output logic         ok_o
);

    assign ok_o = (32'(idx_i) < 32'(N));

    // An out-of-range index matches no line, so oh_o is zero by construction.
    always_comb begin
        // NOTE: every output of a combinational block gets a default first,
        // otherwise any path that skips an assignment infers a latch.
        oh_o = '0;
        for (int i = 0; i < N; i++) begin
            oh_o[i] = (idx_i == W'(i));
        end
    end

endmodule

// File: rtl/dec_8b_pend.sv
// ---------------------------------------------------------------------------
// dec_8b_pend
// Decodes an accepted index stream into registered one-hot pulses and a
// sticky pending bitmap that a consumer acknowledges per bit.
// Ports:
//   clk, rst     : clock (rising edge) and synchronous active-high reset
//   in_val/in_idx: encoded index stream; accept = in_val & in_rdy
//   in_rdy       : low while every pending bit is set
//   out_val      : one-cycle pulse, index decoded last cycle
//   out_oh       : one-hot of that index, zero when out_val=0
//   pend         : sticky pending bitmap
//   clr          : per-bit pending acknowledge
//   err          : one-cycle pulse, accepted index >= N
//   ovf, ovf_clr : sticky duplicate flag and its clear
//   drop_cnt     : saturating duplicate count
// Optional feature: define DEC_DROP_CNT_EN to build the duplicate counter;
// without it drop_cnt is tied to zero.
// ---------------------------------------------------------------------------
module dec_8b_pend
    import dec_pkg::*;
#(
    parameter int N     = DEC_N,
    parameter int W     = $clog2(N),
    parameter int CNT_W = DEC_CNT_W
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             in_val,
    input  logic [W-1:0]     in_idx,
    output logic             in_rdy,
    output logic             out_val,
    output logic [N-1:0]     out_oh,
    output logic [N-1:0]     pend,
    input  logic [N-1:0]     clr,
    output logic             err,
    output logic             ovf,
    input  logic             ovf_clr,
    output logic [CNT_W-1:0] drop_cnt
);

    logic [N-1:0] idx_oh;
    logic         idx_ok;
    logic         accept;
    logic         dup;
    logic [N-1:0] set_vec;

    logic [N-1:0] pend_q, pend_d;
    logic [N-1:0] out_oh_q, out_oh_d;
    logic         out_val_q, out_val_d;
    logic         err_q, err_d;
    logic         ovf_q, ovf_d;

    dec_onehot #(.N(N), .W(W)) u_dec (
        .idx_i (in_idx),
        .oh_o  (idx_oh),
        .ok_o  (idx_ok)
    );

    assign in_rdy = ~&pend_q;
    assign accept = in_val & in_rdy;

    // Only an in-range accept sets a line; idx_oh is already zero otherwise.
    assign set_vec = accept ? idx_oh : '0;

    // A bit being cleared this cycle is not a duplicate: the new set re-arms it.
    assign dup = accept & idx_ok & (|(pend_q & ~clr & idx_oh));

    always_comb begin
        pend_d    = (pend_q & ~clr) | set_vec;
        out_val_d = accept & idx_ok;
        out_oh_d  = set_vec;
        err_d     = accept & ~idx_ok;
        ovf_d     = dup | (ovf_q & ~ovf_clr);
    end

    always_ff @(posedge clk) begin
        // NOTE: sequential state is written with non-blocking assignments so
        // every register samples the pre-edge values of the others.
        if (rst) begin
            pend_q    <= '0;
            out_oh_q  <= '0;
            out_val_q <= 1'b0;
            err_q     <= 1'b0;
            ovf_q     <= 1'b0;
        end else begin
            pend_q    <= pend_d;
            out_oh_q  <= out_oh_d;
            out_val_q <= out_val_d;
            err_q     <= err_d;
            ovf_q     <= ovf_d;
        end
    end

    assign pend    = pend_q;
    assign out_oh  = out_oh_q;
    assign out_val = out_val_q;
    assign err     = err_q;
    assign ovf     = ovf_q;

`ifdef DEC_DROP_CNT_EN
    logic [CNT_W-1:0] cnt_q, cnt_d;

    // ovf_clr restarts the count; a duplicate in that same cycle counts as one.
    always_comb begin
        cnt_d = cnt_q;
        if (ovf_clr) begin
            cnt_d = dup ? CNT_W'(1) : '0;
        end else if (dup && !(&cnt_q)) begin
            cnt_d = cnt_q + CNT_W'(1);
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            cnt_q <= '0;
        end else begin
            cnt_q <= cnt_d;
        end
    end

    assign drop_cnt = cnt_q;
`else
    assign drop_cnt = '0;
`endif

endmodule

// File: tb/tb_dec_8b_pend.sv
// ---------------------------------------------------------------------------
// tb_dec_8b_pend
// Two instances share one stimulus stream: u8 (N=8, CNT_W=2) and u6 (N=6,
// CNT_W=8, so indices 6 and 7 are out of range). A bench-side model tracks
// the expected outputs of both; a negedge process compares every cycle.
// Directed sequences additionally pin literal values.
// ---------------------------------------------------------------------------
module tb_dec_8b_pend;

`ifdef DEC_DROP_CNT_EN
    localparam bit CNT_ON = 1'b1;
`else
    localparam bit CNT_ON = 1'b0;
`endif

    logic       clk = 1'b0;
    logic       rst;
    logic       in_val;
    logic [2:0] in_idx;
    logic [7:0] clr;
    logic       ovf_clr;

    logic       rdy8, val8, err8, ovf8;
    logic [7:0] oh8, pend8;
    logic [1:0] cnt8;

    logic       rdy6, val6, err6, ovf6;
    logic [5:0] oh6, pend6;
    logic [7:0] cnt6;

    int checks   = 0;
    int failures = 0;
    bit live     = 1'b0;

    // Model state per instance (0 = u8, 1 = u6)
    int m_pend[2], m_oh[2], m_cnt[2];
    bit m_val[2], m_err[2], m_ovf[2];

    always #5 clk = ~clk;

    dec_8b_pend #(.N(8), .CNT_W(2)) u8 (
        .clk(clk), .rst(rst), .in_val(in_val), .in_idx(in_idx), .in_rdy(rdy8),
        .out_val(val8), .out_oh(oh8), .pend(pend8), .clr(clr), .err(err8),
        .ovf(ovf8), .ovf_clr(ovf_clr), .drop_cnt(cnt8)
    );

    dec_8b_pend #(.N(6), .CNT_W(8)) u6 (
        .clk(clk), .rst(rst), .in_val(in_val), .in_idx(in_idx), .in_rdy(rdy6),
        .out_val(val6), .out_oh(oh6), .pend(pend6), .clr(clr[5:0]), .err(err6),
        .ovf(ovf6), .ovf_clr(ovf_clr), .drop_cnt(cnt6)
    );

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            failures++;
            $display("FAIL %s got=%0h exp=%0h at %0t", name, act, exp, $time);
        end
    endtask

    // Reference behaviour: what each instance must show after this edge.
    task automatic model_step();
        int n, cmax, mask, c, idx;
        bit acc, ok, dup;
        for (int k = 0; k < 2; k++) begin
            n    = (k == 0) ? 8 : 6;
            cmax = (k == 0) ? 3 : 255;
            mask = (1 << n) - 1;
            c    = int'(clr) & mask;
            idx  = int'(in_idx);
            acc  = in_val && (m_pend[k] != mask);
            ok   = idx < n;
            if (rst) begin
                m_pend[k] = 0; m_oh[k] = 0; m_cnt[k] = 0;
                m_val[k]  = 0; m_err[k] = 0; m_ovf[k] = 0;
            end else begin
                dup       = acc && ok && ((m_pend[k] >> idx) & 1) == 1 && ((c >> idx) & 1) == 0;
                m_pend[k] = (m_pend[k] & ~c) | ((acc && ok) ? (1 << idx) : 0);
                m_val[k]  = acc && ok;
                m_oh[k]   = (acc && ok) ? (1 << idx) : 0;
                m_err[k]  = acc && !ok;
                if (dup) m_ovf[k] = 1'b1;
                else if (ovf_clr) m_ovf[k] = 1'b0;
                if (CNT_ON) begin
                    if (ovf_clr) m_cnt[k] = dup ? 1 : 0;
                    else if (dup && m_cnt[k] < cmax) m_cnt[k]++;
                end
            end
        end
        live = 1'b1;
    endtask

    // Per-cycle comparison against the model.
    always @(negedge clk) begin
        if (live) begin
            check("u8.out_val", 32'(val8),  32'(m_val[0]));
            check("u8.out_oh",  32'(oh8),   32'(m_oh[0]));
            check("u8.pend",    32'(pend8), 32'(m_pend[0]));
            check("u8.in_rdy",  32'(rdy8),  32'(m_pend[0] != 32'hFF));
            check("u8.err",     32'(err8),  32'(m_err[0]));
            check("u8.ovf",     32'(ovf8),  32'(m_ovf[0]));
            check("u8.drop",    32'(cnt8),  32'(m_cnt[0]));
            check("u6.out_val", 32'(val6),  32'(m_val[1]));
            check("u6.out_oh",  32'(oh6),   32'(m_oh[1]));
            check("u6.pend",    32'(pend6), 32'(m_pend[1]));
            check("u6.in_rdy",  32'(rdy6),  32'(m_pend[1] != 32'h3F));
            check("u6.err",     32'(err6),  32'(m_err[1]));
            check("u6.ovf",     32'(ovf6),  32'(m_ovf[1]));
            check("u6.drop",    32'(cnt6),  32'(m_cnt[1]));
        end
    end

    // One clock edge; the model advances with it, inputs change 1ns later.
    task automatic cycle();
        @(posedge clk);
        model_step();
        #1;
    endtask

    task automatic do_rst();
        rst = 1'b1; in_val = 1'b0; clr = '0; ovf_clr = 1'b0;
        cycle();
        rst = 1'b0;
    endtask

    task automatic put(input int idx);
        in_val = 1'b1; in_idx = 3'(idx);
        cycle();
    endtask

    initial begin
        rst = 1'b1; in_val = 1'b0; in_idx = '0; clr = '0; ovf_clr = 1'b0;
        cycle();
        cycle();
        check("rst.pend",    32'(pend8), 32'h0);
        check("rst.out_val", 32'(val8),  32'h0);
        check("rst.in_rdy",  32'(rdy8),  32'h1);
        check("rst.drop",    32'(cnt8),  32'h0);
        rst = 1'b0;

        // Single accept of index 5
        put(5);
        in_val = 1'b0;
        check("i5.out_val", 32'(val8),  32'h1);
        check("i5.out_oh",  32'(oh8),   32'h20);
        check("i5.pend",    32'(pend8), 32'h20);
        check("i5.in_rdy",  32'(rdy8),  32'h1);
        cycle();
        check("i5.pulse_end", 32'(val8), 32'h0);

        // Fill all eight lines back to back
        do_rst();
        for (int i = 0; i < 8; i++) begin
            put(i);
            check("fill.out_val", 32'(val8), 32'h1);
            check("fill.out_oh",  32'(oh8),  32'(1 << i));
        end
        check("full.pend",   32'(pend8), 32'hFF);
        check("full.in_rdy", 32'(rdy8),  32'h0);
        put(3);
        check("full.no_accept", 32'(val8), 32'h0);
        clr = 8'h08;
        cycle();
        clr = '0;
        check("clr3.pend",   32'(pend8), 32'hF7);
        check("clr3.in_rdy", 32'(rdy8),  32'h1);
        cycle();
        in_val = 1'b0;
        check("re3.out_oh", 32'(oh8),   32'h08);
        check("re3.pend",   32'(pend8), 32'hFF);

        // Set/clear collision and duplicate detection
        do_rst();
        put(2);
        clr = 8'h04;
        put(2);
        clr = '0;
        check("coll.pend", 32'(pend8), 32'h04);
        check("coll.ovf",  32'(ovf8),  32'h0);
        put(2);
        in_val = 1'b0;
        check("dup.ovf",     32'(ovf8),  32'h1);
        check("dup.out_val", 32'(val8),  32'h1);
        check("dup.drop",    32'(cnt8),  CNT_ON ? 32'h1 : 32'h0);
        ovf_clr = 1'b1;
        cycle();
        ovf_clr = 1'b0;
        check("oclr.ovf",  32'(ovf8), 32'h0);
        check("oclr.drop", 32'(cnt8), 32'h0);

        // Out-of-range index on the N=6 instance
        do_rst();
        put(7);
        in_val = 1'b0;
        check("oor.err",     32'(err6),  32'h1);
        check("oor.out_val", 32'(val6),  32'h0);
        check("oor.pend",    32'(pend6), 32'h0);
        check("oor.ovf",     32'(ovf6),  32'h0);
        cycle();
        check("oor.err_end", 32'(err6), 32'h0);

        // Counter saturation at 3 with CNT_W=2
        do_rst();
        put(2);
        for (int i = 0; i < 5; i++) put(2);
        check("sat.drop", 32'(cnt8), CNT_ON ? 32'h3 : 32'h0);
        put(2);
        in_val = 1'b0;
        check("sat.hold", 32'(cnt8), CNT_ON ? 32'h3 : 32'h0);

        // Reset during a transfer with pend=A5
        do_rst();
        put(0); put(2); put(5); put(7);
        check("a5.pend", 32'(pend8), 32'hA5);
        rst = 1'b1;
        put(1);
        rst = 1'b0; in_val = 1'b0;
        check("mrst.pend",    32'(pend8), 32'h0);
        check("mrst.out_val", 32'(val8),  32'h0);
        check("mrst.ovf",     32'(ovf8),  32'h0);
        check("mrst.in_rdy",  32'(rdy8),  32'h1);
        cycle();
        check("mrst.lost", 32'(val8), 32'h0);

        // Randomised traffic against the model
        for (int i = 0; i < 3000; i++) begin
            in_val  = ($urandom_range(0, 3) != 0);
            in_idx  = 3'($urandom_range(0, 7));
            clr     = ($urandom_range(0, 3) == 0) ? 8'($urandom & $urandom) : 8'h00;
            ovf_clr = ($urandom_range(0, 15) == 0);
            rst     = ($urandom_range(0, 199) == 0);
            cycle();
        end
        rst = 1'b0; in_val = 1'b0; clr = '0; ovf_clr = 1'b0;
        cycle();

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
